ofm_pack_writer: RTL and testbench
==================================

Name: ofm_pack_writer

Overview:
- Downstream of the 16-PE convolution sub-top; consumes the per-PE 8-bit OFM bytes and their finish strobes.
- Collects one output pixel, 16 channels wide, then packs it MSB-first into four 32-bit words.
- Writes those words to the OFM BRAM through a valid/ready write port.
- Counts pixels per layer and flags completion and overrun.

Parameters:
- ADDR_W, 16, width of the OFM BRAM word address.
- NUM_PIXELS, 3136, output pixels per layer (56x56).
- BASE_ADDR, 0, first word address of the OFM region.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms the block for a new layer
- pe_finish  in  16  bit p high = ofm_in byte p valid this cycle
- ofm_in  in  128  byte p at bits [8p+7:8p], PE 0..15
- wr_ready  in  1  BRAM side accepts the current write beat
- ofm_we  out  1  write beat valid
- ofm_addr  out  ADDR_W  word address of the current beat
- ofm_wdata  out  32  packed word
- busy  out  1  armed and layer not complete
- done  out  1  level; high after NUM_PIXELS pixels are written
- overrun  out  1  sticky; a finish strobe arrived while the block could not accept it

Behaviour:
- Reset: every output 0; state IDLE; pixel_cnt 0; beat 0; sticky mask 0; byte buffer 0.
- Reset mid-operation abandons any partial pixel or pending beat. No write is issued after reset.
- States:
  - IDLE: start -> COLLECT. Also clears pixel_cnt, done, overrun and mask; sets busy.
  - COLLECT: for each p with pe_finish[p]=1, latch ofm_in byte p into buf[p] and set mask[p].
    - A bit already set in mask that strobes again overwrites buf[p] and sets overrun.
    - When mask is all ones (including bits set this cycle) -> WRITE next cycle with beat=0.
    - With all 16 bits strobed in one cycle, WRITE is entered on the following cycle.
  - WRITE:
    - ofm_we=1.
    - ofm_addr = BASE_ADDR + 4*pixel_cnt + beat, truncated to ADDR_W.
    - ofm_wdata = {buf[4b], buf[4b+1], buf[4b+2], buf[4b+3]} with b=beat; buf[4b] in bits [31:24].
    - Addr and data stay stable while wr_ready=0.
    - On ofm_we && wr_ready: beat increments.
    - On beat 3 accepted: mask clears, pixel_cnt increments.
    - If pixel_cnt+1 == NUM_PIXELS -> DONE; otherwise -> COLLECT.
    - Any pe_finish bit high in WRITE sets overrun; its byte is dropped.
  - DONE: done=1, busy=0, ofm_we=0; start -> same actions as IDLE+start.
- start in COLLECT or WRITE is ignored.
- pe_finish in IDLE or DONE is ignored; overrun is not set.
- Minimum latency: strobe cycle -> first ofm_we 1 cycle later. A pixel takes 4 beats with wr_ready held high.
- ofm_we is registered. ofm_addr and ofm_wdata are registered or derived from registered state only, with no combinational path from pe_finish.

Optional Feature:
- Macro OFM_RELU_EN.
- Defined: each byte is treated as signed two's complement at latch time. Values 0x80..0xFF are stored as 0x00; 0x00..0x7F pass unchanged.
- Undefined: bytes are stored raw.
- Without the macro, no clamp logic is present.

Test Plan:
1. Reset, then start, then pe_finish=16'hFFFF with ofm_in bytes p=p+1 (0x01..0x10), wr_ready=1 -> writes in order: addr0=0x01020304, addr1=0x05060708, addr2=0x090A0B0C, addr3=0x0D0E0F10. pixel_cnt=1.
2. Staggered strobes: PEs 0..7 at cycle t, PEs 8..15 at cycle t+3 -> first ofm_we at t+4. Same packing as scenario 1.
3. wr_ready low for 5 cycles on beat 1 -> ofm_addr=1 and ofm_wdata held stable. Beat 2 follows 1 cycle after wr_ready rises.
4. NUM_PIXELS=2, BASE_ADDR=0x100, two full pixels -> addresses 0x100..0x107. done=1 and busy=0 after the beat at 0x107. A further pe_finish produces no write.
5. pe_finish[3] pulsed twice before the mask completes, and a strobe during WRITE -> overrun=1 and remains set. The second byte for PE 3 is the one written. A new start clears overrun.
6. With OFM_RELU_EN: bytes 0xFF, 0x80, 0x7F, 0x00 into PEs 0..3 -> word 0 = 0x00007F00. Without the macro -> 0xFF807F00.

Source files
------------

// File: rtl/ofm_pack_writer.sv
// Collects one 16-channel OFM pixel from the PE finish strobes and writes it to BRAM as four MSB-first 32-bit words.
// Optional OFM_RELU_EN: clamp negative bytes to zero as they are latched.
module ofm_pack_writer #(
    parameter int ADDR_W     = 16,
    parameter int NUM_PIXELS = 3136,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       pe_finish,
    input  logic [127:0]      ofm_in,
    input  logic              wr_ready,
    output logic              ofm_we,
    output logic [ADDR_W-1:0] ofm_addr,
    output logic [31:0]       ofm_wdata,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int CNT_W = $clog2(NUM_PIXELS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t           state;
    logic [7:0]       byte_buf [16];
    logic [15:0]      mask;
    logic [15:0]      mask_next;
    logic [CNT_W-1:0] pixel_cnt;
    logic [1:0]       beat;
    logic [ADDR_W-1:0] addr_calc;
    logic             last_pixel;

    function automatic logic [7:0] clamp(input logic [7:0] b);
`ifdef OFM_RELU_EN
        return b[7] ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    assign mask_next  = mask | pe_finish;
    assign last_pixel = (32'(pixel_cnt) + 32'd1) == 32'(NUM_PIXELS);
    assign addr_calc  = ADDR_W'(BASE_ADDR) + ADDR_W'({pixel_cnt, 2'b00}) + ADDR_W'(beat);

    // Address and data come only from registered state; gating with ofm_we keeps them zero outside WRITE.
    assign ofm_addr  = ofm_we ? addr_calc : '0;
    assign ofm_wdata = ofm_we ? {byte_buf[{beat, 2'd0}], byte_buf[{beat, 2'd1}],
                                 byte_buf[{beat, 2'd2}], byte_buf[{beat, 2'd3}]} : '0;

    // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= '0;
            pixel_cnt <= '0;
            beat      <= '0;
            ofm_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            // NOTE: the byte buffer is reset too, so nothing from an abandoned pixel can ever be written.
            for (int p = 0; p < 16; p++) begin
                byte_buf[4'(p)] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= COLLECT;
                        pixel_cnt <= '0;
                        mask      <= '0;
                        beat      <= '0;
                        done      <= 1'b0;
                        overrun   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                COLLECT: begin
                    for (int p = 0; p < 16; p++) begin
                        if (pe_finish[4'(p)]) begin
                            byte_buf[4'(p)] <= clamp(ofm_in[8*p +: 8]);
                        end
                    end
                    mask <= mask_next;
                    if (|(mask & pe_finish)) begin
                        overrun <= 1'b1;
                    end
                    if (&mask_next) begin
                        state  <= WRITE;
                        ofm_we <= 1'b1;
                        beat   <= '0;
                    end
                end

                WRITE: begin
                    // Strobes cannot be buffered while the pixel drains; drop them and flag it.
                    if (|pe_finish) begin
                        overrun <= 1'b1;
                    end
                    if (wr_ready) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            ofm_we    <= 1'b0;
                            mask      <= '0;
                            pixel_cnt <= pixel_cnt + CNT_W'(1);
                            if (last_pixel) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= COLLECT;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_pack_writer.sv
// Directed self-checking bench for ofm_pack_writer (NUM_PIXELS=2, BASE_ADDR=0x100).
// Expected word 0 of the clamp step follows OFM_RELU_EN.
module tb_ofm_pack_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  pe_finish;
    logic [127:0] ofm_in;
    logic         wr_ready;
    logic         ofm_we;
    logic [15:0]  ofm_addr;
    logic [31:0]  ofm_wdata;
    logic         busy;
    logic         done;
    logic         overrun;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ofm_pack_writer #(
        .ADDR_W(16),
        .NUM_PIXELS(2),
        .BASE_ADDR('h100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pe_finish(pe_finish),
        .ofm_in(ofm_in),
        .wr_ready(wr_ready),
        .ofm_we(ofm_we),
        .ofm_addr(ofm_addr),
        .ofm_wdata(ofm_wdata),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [15:0] addr, input logic [31:0] data);
        check({tag, "_we"}, 32'(ofm_we), 32'd1);
        check({tag, "_addr"}, 32'(ofm_addr), 32'(addr));
        check({tag, "_data"}, ofm_wdata, data);
    endtask

    task automatic check_flags(input string tag, input logic b, input logic d, input logic o);
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_overrun"}, 32'(overrun), 32'(o));
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] base);
        logic [127:0] r;
        for (int p = 0; p < 16; p++) begin
            r[8*p +: 8] = base + 8'(p);
        end
        return r;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] relu_word0;
        reset     = 1'b1;
        start     = 1'b0;
        pe_finish = '0;
        ofm_in    = '0;
        wr_ready  = 1'b1;
        tick();
        tick();

        check("rst_we", 32'(ofm_we), 32'd0);
        check("rst_addr", 32'(ofm_addr), 32'd0);
        check("rst_data", ofm_wdata, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        reset = 1'b0;
        pe_finish = 16'hFFFF;
        ofm_in    = ramp(8'h01);
        tick();
        check("idle_strobe_we", 32'(ofm_we), 32'd0);
        check_flags("idle_strobe", 1'b0, 1'b0, 1'b0);
        pe_finish = '0;
        pulse_start();
        check_flags("armed", 1'b1, 1'b0, 1'b0);

        // All sixteen strobes in one cycle: write starts on the next cycle.
        pe_finish = 16'hFFFF;
        ofm_in    = ramp(8'h01);
        tick();
        pe_finish = '0;
        check_beat("s1_b0", 16'h100, 32'h01020304);
        tick();
        check_beat("s1_b1", 16'h101, 32'h05060708);
        tick();
        check_beat("s1_b2", 16'h102, 32'h090A0B0C);
        tick();
        check_beat("s1_b3", 16'h103, 32'h0D0E0F10);
        tick();
        check("s1_end_we", 32'(ofm_we), 32'd0);
        check_flags("s1_end", 1'b1, 1'b0, 1'b0);

        // Staggered strobes: low half at t, high half at t+3, write at t+4.
        pe_finish = 16'h00FF;
        tick();
        pe_finish = '0;
        check("s2_t1_we", 32'(ofm_we), 32'd0);
        tick();
        check("s2_t2_we", 32'(ofm_we), 32'd0);
        tick();
        check("s2_t3_we", 32'(ofm_we), 32'd0);
        pe_finish = 16'hFF00;
        tick();
        pe_finish = '0;
        check_beat("s2_b0", 16'h104, 32'h01020304);
        tick();
        check_beat("s2_b1", 16'h105, 32'h05060708);
        tick();
        check_beat("s2_b2", 16'h106, 32'h090A0B0C);
        tick();
        check_beat("s2_b3", 16'h107, 32'h0D0E0F10);
        tick();
        check("s4_done_we", 32'(ofm_we), 32'd0);
        check_flags("s4_done", 1'b0, 1'b1, 1'b0);

        pe_finish = 16'hFFFF;
        tick();
        tick();
        pe_finish = '0;
        check("s4_post_we", 32'(ofm_we), 32'd0);
        check_flags("s4_post", 1'b0, 1'b1, 1'b0);

        // New layer; stall beat 1 for five cycles.
        pulse_start();
        check_flags("s3_armed", 1'b1, 1'b0, 1'b0);
        pe_finish = 16'hFFFF;
        ofm_in    = ramp(8'hA0);
        tick();
        pe_finish = '0;
        check_beat("s3_b0", 16'h100, 32'hA0A1A2A3);
        tick();
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_beat($sformatf("s3_stall%0d", i), 16'h101, 32'hA4A5A6A7);
            tick();
        end
        wr_ready = 1'b1;
        check_beat("s3_b1", 16'h101, 32'hA4A5A6A7);
        tick();
        check_beat("s3_b2", 16'h102, 32'hA8A9AAAB);
        tick();
        check_beat("s3_b3", 16'h103, 32'hACADAEAF);
        tick();
        check("s3_end_we", 32'(ofm_we), 32'd0);

        // PE 3 strobes twice, then a strobe during WRITE is dropped.
        pe_finish = 16'h0008;
        ofm_in    = '0;
        ofm_in[31:24] = 8'h11;
        tick();
        check("s5_first_overrun", 32'(overrun), 32'd0);
        ofm_in[31:24] = 8'h33;
        tick();
        check("s5_dup_overrun", 32'(overrun), 32'd1);
        pe_finish = 16'hFFF7;
        ofm_in    = ramp(8'h50);
        tick();
        pe_finish = 16'h0010;
        ofm_in    = {16{8'hEE}};
        check_beat("s5_b0", 16'h104, 32'h50515233);
        tick();
        pe_finish = '0;
        check_beat("s5_b1", 16'h105, 32'h54555657);
        tick();
        check_beat("s5_b2", 16'h106, 32'h58595A5B);
        tick();
        check_beat("s5_b3", 16'h107, 32'h5C5D5E5F);
        tick();
        check_flags("s5_done", 1'b0, 1'b1, 1'b1);
        pulse_start();
        check_flags("s5_restart", 1'b1, 1'b0, 1'b0);

        // Sign clamp on latch.
`ifdef OFM_RELU_EN
        relu_word0 = 32'h00007F00;
`else
        relu_word0 = 32'hFF807F00;
`endif
        ofm_in = ramp(8'h10);
        ofm_in[31:0] = 32'h007F80FF;
        pe_finish = 16'h000F;
        tick();
        pe_finish = 16'hFFF0;
        tick();
        pe_finish = '0;
        check_beat("s6_b0", 16'h100, relu_word0);
        tick();
        check_beat("s6_b1", 16'h101, 32'h14151617);
        tick();
        tick();
        tick();
        check("s6_end_we", 32'(ofm_we), 32'd0);

        // Reset with a partial pixel pending, then verify a clean restart.
        pe_finish = 16'h00FF;
        ofm_in    = ramp(8'hC0);
        tick();
        reset = 1'b1;
        pe_finish = '0;
        tick();
        check("mid_rst_we", 32'(ofm_we), 32'd0);
        check("mid_rst_addr", 32'(ofm_addr), 32'd0);
        check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        pe_finish = 16'hFFFF;
        tick();
        tick();
        pe_finish = '0;
        check("post_rst_we", 32'(ofm_we), 32'd0);
        pulse_start();
        pe_finish = 16'hFFFF;
        ofm_in    = ramp(8'h60);
        tick();
        pe_finish = '0;
        check_beat("post_rst_b0", 16'h100, 32'h60616263);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
